// File: rtl/cmd_file_register.sv
// rtl/cmd_file_register.sv - GPO instruction decoder and GPI readback between the micro and the convolution datapath
// Optional feature: define KERNEL_SEL_READBACK_EN to echo the kernel selection on o_data_to_micro.
module cmd_file_register #(
  parameter int NB_C0M  = 7,
  parameter int NB_DATA = 24,
  parameter int NB_INST = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_INST-1:0] i_cmd_from_micro,
  input  logic               i_frame_ready,
  input  logic [NB_INST-1:0] i_pixels_from_mem,
  output logic [NB_INST-1:0] o_data_to_micro,
  output logic [NB_DATA-1:0] o_pixels_from_micro,
  output logic [1:0]         o_kernel_sel,
  output logic               o_load,
  output logic               o_get_pixels,
  output logic               o_start_conv
);

  localparam logic [NB_C0M-1:0] CMD_KERNEL_SEL     = NB_C0M'(0);
  localparam logic [NB_C0M-1:0] CMD_LOAD_FRAME     = NB_C0M'(1);
  localparam logic [NB_C0M-1:0] CMD_END_FRAME      = NB_C0M'(2);
  localparam logic [NB_C0M-1:0] CMD_IS_FRAME_READY = NB_C0M'(3);
  localparam logic [NB_C0M-1:0] CMD_GET_FRAME      = NB_C0M'(4);

  logic               enable;
  logic [NB_C0M-1:0]  cmd;
  logic [NB_DATA-1:0] data;
  logic               en_d;
  logic               trigger;
  logic               cap_pend;

  assign enable  = i_cmd_from_micro[NB_INST-1];
  assign cmd     = i_cmd_from_micro[NB_INST-2 -: NB_C0M];
  assign data    = i_cmd_from_micro[NB_DATA-1:0];
  assign trigger = enable & ~en_d;

  // The triggered command's write comes after the capture write, so it wins a collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_d                <= 1'b0;
      cap_pend            <= 1'b0;
      o_data_to_micro     <= '0;
      o_pixels_from_micro <= '0;
      o_kernel_sel        <= '0;
      o_load              <= 1'b0;
      o_get_pixels        <= 1'b0;
      o_start_conv        <= 1'b0;
    end else begin
      en_d         <= enable;
      o_load       <= 1'b0;
      o_get_pixels <= 1'b0;
      o_start_conv <= 1'b0;
      // Memory registers its word on the edge the fetch strobe drops; take it one edge later.
      cap_pend     <= o_get_pixels;
      if (cap_pend) begin
        o_data_to_micro <= i_pixels_from_mem;
      end
      if (trigger) begin
        case (cmd)
          CMD_KERNEL_SEL: begin
            o_kernel_sel <= data[1:0];
`ifdef KERNEL_SEL_READBACK_EN
            o_data_to_micro <= {{(NB_INST-2){1'b0}}, data[1:0]};
`endif
          end
          CMD_LOAD_FRAME: begin
            o_pixels_from_micro <= data;
            o_load              <= 1'b1;
          end
          CMD_END_FRAME: begin
            o_start_conv <= 1'b1;
          end
          CMD_IS_FRAME_READY: begin
            o_data_to_micro <= {{(NB_INST-1){1'b0}}, i_frame_ready};
          end
          CMD_GET_FRAME: begin
            o_get_pixels <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_file_register.sv
// tb/tb_cmd_file_register.sv - self-checking bench for cmd_file_register
module tb_cmd_file_register;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_cmd_from_micro = '0;
  logic        i_frame_ready = 1'b0;
  logic [31:0] i_pixels_from_mem = '0;
  logic [31:0] o_data_to_micro;
  logic [23:0] o_pixels_from_micro;
  logic [1:0]  o_kernel_sel;
  logic        o_load;
  logic        o_get_pixels;
  logic        o_start_conv;

  int total = 0;
  int bad   = 0;

  cmd_file_register dut (
    .clock              (clock),
    .reset              (reset),
    .i_cmd_from_micro   (i_cmd_from_micro),
    .i_frame_ready      (i_frame_ready),
    .i_pixels_from_mem  (i_pixels_from_mem),
    .o_data_to_micro    (o_data_to_micro),
    .o_pixels_from_micro(o_pixels_from_micro),
    .o_kernel_sel       (o_kernel_sel),
    .o_load             (o_load),
    .o_get_pixels       (o_get_pixels),
    .o_start_conv       (o_start_conv)
  );

  always #5 clock = ~clock;

`ifdef KERNEL_SEL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  function automatic logic [31:0] preload(input int i);
    return {8'h5A, 8'(i), 16'hC0DE};
  endfunction

  // Frame memory: stores loaded words, returns a word one edge after a fetch strobe.
  logic [31:0] mem [64];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  bit          mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= preload(i);
      mem_init <= 1'b1;
    end else begin
      if (o_load) begin
        mem[wr_ptr] <= {8'h00, o_pixels_from_micro};
        wr_ptr <= wr_ptr + 6'd1;
      end
      if (o_get_pixels) begin
        i_pixels_from_mem <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 6'd1;
      end
    end
  end

  // Reference model: per-edge effects of the instruction rules, scheduled captures by cycle number.
  logic [31:0] ref_mem [64];
  int          ref_wr = 0;
  int          ref_rd = 0;
  int          cyc = 0;
  bit          m_en_prev = 0;
  int          m_cap_at = -1;
  logic [31:0] m_cap_val = '0;
  logic [1:0]  m_ks = '0;
  logic [23:0] m_pix = '0;
  logic [31:0] m_dat = '0;
  bit          m_load = 0, m_get = 0, m_start = 0;

  task automatic model_edge();
    bit          trig, wrote, cap_due;
    logic [31:0] cap_v;
    logic [23:0] d;
    cyc++;
    m_load = 0; m_get = 0; m_start = 0;
    if (reset) begin
      m_ks = '0; m_pix = '0; m_dat = '0;
      m_en_prev = 0; m_cap_at = -1;
    end else begin
      cap_due = (m_cap_at == cyc);
      cap_v   = m_cap_val;
      if (cap_due) m_cap_at = -1;
      trig  = i_cmd_from_micro[31] && !m_en_prev;
      m_en_prev = i_cmd_from_micro[31];
      wrote = 0;
      d = i_cmd_from_micro[23:0];
      if (trig) begin
        case (int'(i_cmd_from_micro[30:24]))
          0: begin
            m_ks = d[1:0];
            if (RB) begin m_dat = {30'b0, d[1:0]}; wrote = 1; end
          end
          1: begin
            m_pix = d; m_load = 1;
            ref_mem[ref_wr % 64] = {8'h00, d};
            ref_wr++;
          end
          2: m_start = 1;
          3: begin m_dat = {31'b0, i_frame_ready}; wrote = 1; end
          4: begin
            m_get = 1;
            m_cap_at = cyc + 2;
            m_cap_val = ref_mem[ref_rd % 64];
            ref_rd++;
          end
          default: ;
        endcase
      end
      if (cap_due && !wrote) m_dat = cap_v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [31:0] c, input bit fr);
    reset = r;
    i_cmd_from_micro = c;
    i_frame_ready = fr;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("model_kernel_sel", 32'(o_kernel_sel), 32'(m_ks));
    chk("model_pixels", 32'(o_pixels_from_micro), 32'(m_pix));
    chk("model_data", o_data_to_micro, m_dat);
    chk("model_load", 32'(o_load), 32'(m_load));
    chk("model_get", 32'(o_get_pixels), 32'(m_get));
    chk("model_start", 32'(o_start_conv), 32'(m_start));
  endtask

  function automatic logic [31:0] mk(input int c, input logic [23:0] d);
    return {1'b1, 7'(c), d};
  endfunction

  typedef struct {
    bit          rst;
    logic [31:0] cmd;
    bit          fr;
    logic [1:0]  ks;
    bit          load;
    bit          start;
    bit          get;
    logic [23:0] pix;
    logic [31:0] dat;
  } vec_t;

  function automatic vec_t v(input bit rst, input logic [31:0] c, input bit fr, input logic [1:0] ks,
                             input bit ld, input bit st, input bit gt, input logic [23:0] pix,
                             input logic [31:0] dat);
    vec_t t;
    t.rst = rst; t.cmd = c; t.fr = fr; t.ks = ks; t.load = ld; t.start = st; t.get = gt;
    t.pix = pix; t.dat = dat;
    return t;
  endfunction

  vec_t tbl [22];

  initial begin
    logic [31:0] k3, k2;
    k3 = RB ? 32'd3 : 32'd0;
    k2 = RB ? 32'd2 : 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);

    tbl[0]  = v(1, 32'h0, 0, 0, 0, 0, 0, 24'h0, 32'h0);
    tbl[1]  = v(0, mk(0, 24'd3), 0, 3, 0, 0, 0, 24'h0, k3);
    tbl[2]  = v(0, 32'h0, 0, 3, 0, 0, 0, 24'h0, k3);
    tbl[3]  = v(0, mk(0, 24'd2), 0, 2, 0, 0, 0, 24'h0, k2);
    for (int i = 4; i <= 8; i++) tbl[i] = v(0, mk(0, 24'd1), 0, 2, 0, 0, 0, 24'h0, k2);
    tbl[9]  = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h0, k2);
    tbl[10] = v(0, mk(3, 24'h0), 1, 2, 0, 0, 0, 24'h0, 32'h1);
    tbl[11] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h0, 32'h1);
    tbl[12] = v(0, mk(3, 24'h0), 0, 2, 0, 0, 0, 24'h0, 32'h0);
    tbl[13] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h0, 32'h0);
    tbl[14] = v(0, mk(1, 24'h2BFF1D), 0, 2, 1, 0, 0, 24'h2BFF1D, 32'h0);
    tbl[15] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h2BFF1D, 32'h0);
    tbl[16] = v(0, mk(1, 24'h7FABFF), 0, 2, 1, 0, 0, 24'h7FABFF, 32'h0);
    tbl[17] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h7FABFF, 32'h0);
    tbl[18] = v(0, mk(2, 24'h00FF00), 0, 2, 0, 1, 0, 24'h7FABFF, 32'h0);
    tbl[19] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h7FABFF, 32'h0);
    tbl[20] = v(0, mk(5, 24'hABCDEF), 0, 2, 0, 0, 0, 24'h7FABFF, 32'h0);
    tbl[21] = v(0, 32'h0, 0, 2, 0, 0, 0, 24'h7FABFF, 32'h0);

    @(negedge clock);
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].cmd, tbl[i].fr);
      chk($sformatf("tbl_ks[%0d]", i), 32'(o_kernel_sel), 32'(tbl[i].ks));
      chk($sformatf("tbl_load[%0d]", i), 32'(o_load), 32'(tbl[i].load));
      chk($sformatf("tbl_start[%0d]", i), 32'(o_start_conv), 32'(tbl[i].start));
      chk($sformatf("tbl_get[%0d]", i), 32'(o_get_pixels), 32'(tbl[i].get));
      chk($sformatf("tbl_pix[%0d]", i), 32'(o_pixels_from_micro), 32'(tbl[i].pix));
      chk($sformatf("tbl_dat[%0d]", i), o_data_to_micro, tbl[i].dat);
    end

    // Three fetches at minimum spacing; each readback lands two edges after its trigger.
    step(0, mk(4, 24'h0), 0);
    chk("get1_strobe", 32'(o_get_pixels), 32'h1);
    step(0, 32'h0, 0);
    chk("get1_strobe_end", 32'(o_get_pixels), 32'h0);
    step(0, mk(4, 24'h0), 0);
    chk("get1_data", o_data_to_micro, 32'h002BFF1D);
    step(0, 32'h0, 0);
    step(0, mk(4, 24'h0), 0);
    chk("get2_data", o_data_to_micro, 32'h007FABFF);
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    chk("get3_data", o_data_to_micro, 32'h5A02C0DE);

    // Status write on the capture edge wins; the capture is dropped.
    step(0, mk(4, 24'h0), 0);
    step(0, 32'h0, 0);
    step(0, mk(3, 24'h0), 1);
    chk("collide_status", o_data_to_micro, 32'h1);
    step(0, 32'h0, 0);
    chk("collide_hold", o_data_to_micro, 32'h1);

    // Reset during a load pulse.
    step(0, mk(1, 24'h123456), 0);
    chk("rst_load_pulse", 32'(o_load), 32'h1);
    step(1, 32'h0, 0);
    chk("rst_load_strobe", 32'(o_load), 32'h0);
    chk("rst_load_pix", 32'(o_pixels_from_micro), 32'h0);
    chk("rst_load_ks", 32'(o_kernel_sel), 32'h0);
    step(0, 32'h0, 0);

    // Reset on the capture edge, then on the edge the fetch strobe drops.
    step(0, mk(4, 24'h0), 0);
    step(0, 32'h0, 0);
    step(1, 32'h0, 0);
    chk("rst_e2_data", o_data_to_micro, 32'h0);
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    chk("rst_e2_nocap", o_data_to_micro, 32'h0);
    step(0, mk(4, 24'h0), 0);
    step(1, 32'h0, 0);
    chk("rst_e1_get", 32'(o_get_pixels), 32'h0);
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    chk("rst_e1_nocap", o_data_to_micro, 32'h0);

    // Enable already high as reset releases fires once.
    step(1, mk(0, 24'd1), 0);
    step(0, mk(0, 24'd1), 0);
    chk("en_at_reset_ks", 32'(o_kernel_sel), 32'h1);
    step(0, mk(0, 24'd2), 0);
    chk("en_at_reset_hold", 32'(o_kernel_sel), 32'h1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] c;
      c = {($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, 7'($urandom_range(0, 7)), 24'($urandom)};
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, c, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
